// File: rtl/core_sequencer_pkg.sv
// Shared types and default address map for the core sequencer.
// Imported by the sequencer top and its stall timer.
package core_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_MEMRD,
        S_EXEC,
        S_WB,
        S_HALT
    } state_e;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h8000_0000;
    localparam logic [31:0] DEF_PASS_ADDR    = 32'h8000_0100;
    localparam logic [31:0] DEF_FAIL_ADDR    = 32'h8000_0104;

endpackage

// File: rtl/core_sequencer_if.sv
// Control/status bundle between the core datapath and its sequencer.
// The slave side is the sequencer; the master side drives the inputs.
interface core_sequencer_if #(
    parameter int XLEN     = 32,
    parameter int RETIRE_W = 32
);
    logic            im_ready;
    logic            dm_ready;
    logic            is_mem_op;
    logic            take_target;
    logic [XLEN-1:0] target_addr;
    logic            step_mode;
    logic            step_req;
    logic            halt_req;

    logic                fetch_en;
    logic                memrd_en;
    logic                exec_en;
    logic                wb_en;
    logic [XLEN-1:0]     pc;
    logic                halted;
    logic                pass;
    logic                fail;
    logic                timeout;
    logic [RETIRE_W-1:0] retired;

    modport master (
        output im_ready, dm_ready, is_mem_op, take_target,
        output target_addr, step_mode, step_req, halt_req,
        input  fetch_en, memrd_en, exec_en, wb_en,
        input  pc, halted, pass, fail, timeout, retired
    );

    modport slave (
        input  im_ready, dm_ready, is_mem_op, take_target,
        input  target_addr, step_mode, step_req, halt_req,
        output fetch_en, memrd_en, exec_en, wb_en,
        output pc, halted, pass, fail, timeout, retired
    );

endinterface

// File: rtl/core_sequencer_stall_timer.sv
// Saturating stall counter; flags expiry when the count reaches all-ones.
// Any non-stall cycle clears the count, so each wait phase starts fresh.
module core_sequencer_stall_timer #(
    parameter int W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall_i,
    output logic expire_o
);
    localparam logic [W-1:0] MAX = '1;
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (stall_i) begin
            cnt_d = (cnt_q == MAX) ? cnt_q : cnt_q + ONE;
        end
    end

    assign expire_o = stall_i && (cnt_d == MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle instruction phase sequencer with step, halt and timeout.
// Drives one-hot phase strobes, owns the PC and the retire counter.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [XLEN-1:0] PASS_ADDR    = DEF_PASS_ADDR,
    parameter logic [XLEN-1:0] FAIL_ADDR    = DEF_FAIL_ADDR,
    parameter int              TIMEOUT_W    = 8,
    parameter int              RETIRE_W     = 32
) (
    input logic             clk,
    input logic             rst_n,
    core_sequencer_if.slave bus
);
    localparam logic [XLEN-1:0]     PC_INC  = XLEN'(4);
    localparam logic [RETIRE_W-1:0] RET_INC = RETIRE_W'(1);

    state_e state_q, state_d;

    logic [XLEN-1:0]     pc_q, pc_d, pc_nxt;
    logic [RETIRE_W-1:0] ret_q, ret_d;
    logic halted_q, halted_d;
    logic pass_q, pass_d;
    logic fail_q, fail_d;
    logic tmo_q, tmo_d;
    logic hpend_q, hpend_d;
    logic stall, expire;

    assign stall = (state_q == S_FETCH && !bus.im_ready) ||
                   (state_q == S_MEMRD && !bus.dm_ready);

    core_sequencer_stall_timer #(
        .W (TIMEOUT_W)
    ) u_stall_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall_i  (stall),
        .expire_o (expire)
    );

    assign pc_nxt = bus.take_target ? bus.target_addr : pc_q + PC_INC;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ret_d   = ret_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        tmo_d   = tmo_q;
        hpend_d = hpend_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.halt_req) begin
                    state_d = S_HALT;
                end else if (!bus.step_mode || bus.step_req) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (bus.halt_req) begin
                    state_d = S_HALT;
                end else if (bus.im_ready) begin
                    state_d = bus.is_mem_op ? S_MEMRD : S_EXEC;
                end else if (expire) begin
                    state_d = S_HALT;
                    tmo_d   = 1'b1;
                end
            end
            S_MEMRD: begin
                if (bus.halt_req) begin
                    state_d = S_HALT;
                end else if (bus.dm_ready) begin
                    state_d = S_EXEC;
                end else if (expire) begin
                    state_d = S_HALT;
                    tmo_d   = 1'b1;
                end
            end
            S_EXEC: begin
                // A halt seen here must still let this instruction retire.
                state_d = S_WB;
                if (bus.halt_req) begin
                    hpend_d = 1'b1;
                end
            end
            S_WB: begin
                pc_d    = pc_nxt;
                ret_d   = ret_q + RET_INC;
                hpend_d = 1'b0;
                if (pc_nxt == PASS_ADDR) begin
                    state_d = S_HALT;
                    pass_d  = 1'b1;
                end else if (pc_nxt == FAIL_ADDR) begin
                    state_d = S_HALT;
                    fail_d  = 1'b1;
                end else if (bus.halt_req || hpend_q) begin
                    state_d = S_HALT;
                end else begin
                    state_d = bus.step_mode ? S_IDLE : S_FETCH;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        halted_d = halted_q || (state_d == S_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_VECTOR;
            ret_q    <= '0;
            halted_q <= 1'b0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
            tmo_q    <= 1'b0;
            hpend_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ret_q    <= ret_d;
            halted_q <= halted_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            tmo_q    <= tmo_d;
            hpend_q  <= hpend_d;
        end
    end

    assign bus.fetch_en = (state_q == S_FETCH);
    assign bus.memrd_en = (state_q == S_MEMRD);
    assign bus.exec_en  = (state_q == S_EXEC);
    assign bus.wb_en    = (state_q == S_WB);
    assign bus.pc       = pc_q;
    assign bus.retired  = ret_q;
    assign bus.halted   = halted_q;
    assign bus.pass     = pass_q;
    assign bus.fail     = fail_q;
    assign bus.timeout  = tmo_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed self-checking bench for core_sequencer.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_core_sequencer;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    core_sequencer_if #(.XLEN(32), .RETIRE_W(32)) bif ();

    core_sequencer #(
        .TIMEOUT_W (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    int n_pass = 0;
    int n_chk  = 0;

    // {fetch, memrd, exec, wb}
    function automatic logic [3:0] strb();
        return {bif.fetch_en, bif.memrd_en, bif.exec_en, bif.wb_en};
    endfunction

    // {halted, pass, fail, timeout}
    function automatic logic [3:0] flags();
        return {bif.halted, bif.pass, bif.fail, bif.timeout};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        rst_n           = 1'b0;
        bif.im_ready    = 1'b1;
        bif.dm_ready    = 1'b1;
        bif.is_mem_op   = 1'b0;
        bif.take_target = 1'b0;
        bif.target_addr = 32'h0;
        bif.step_mode   = 1'b1;
        bif.step_req    = 1'b0;
        bif.halt_req    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pc", bif.pc, 32'h8000_0000);
        chk("rst_ret", bif.retired, 32'd0);
        chk("rst_strb", {28'd0, strb()}, 32'h0);
        chk("rst_flags", {28'd0, flags()}, 32'h0);

        // free run, 3 cycles per instruction
        rst_n         = 1'b1;
        bif.step_mode = 1'b0;
        @(negedge clk);
        chk("fr_fetch", {28'd0, strb()}, 32'h8);
        @(negedge clk);
        chk("fr_exec", {28'd0, strb()}, 32'h2);
        @(negedge clk);
        chk("fr_wb", {28'd0, strb()}, 32'h1);
        repeat (10) @(negedge clk);
        chk("fr_pc", bif.pc, 32'h8000_0010);
        chk("fr_ret", bif.retired, 32'd4);
        chk("fr_next_fetch", {28'd0, strb()}, 32'h8);
        bif.step_mode = 1'b1;
        repeat (3) @(negedge clk);
        chk("to_step_idle", {28'd0, strb()}, 32'h0);
        chk("to_step_ret", bif.retired, 32'd5);

        // memory op, dm_ready low for 3 MEMRD cycles
        bif.is_mem_op = 1'b1;
        bif.dm_ready  = 1'b0;
        bif.step_req  = 1'b1;
        @(negedge clk);
        bif.step_req = 1'b0;
        chk("mem_fetch", {28'd0, strb()}, 32'h8);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("mem_rd%0d", k), {28'd0, strb()}, 32'h4);
            bif.dm_ready = (k == 4);
        end
        @(negedge clk);
        chk("mem_exec", {28'd0, strb()}, 32'h2);
        @(negedge clk);
        chk("mem_wb", {28'd0, strb()}, 32'h1);
        bif.is_mem_op = 1'b0;
        @(negedge clk);
        chk("mem_idle", {28'd0, strb()}, 32'h0);
        chk("mem_ret", bif.retired, 32'd6);
        chk("mem_pc", bif.pc, 32'h8000_0018);

        // single step, two pulses 10 cycles apart
        bif.step_req = 1'b1;
        @(negedge clk);
        bif.step_req = 1'b0;
        repeat (9) @(negedge clk);
        chk("step1_idle", {28'd0, strb()}, 32'h0);
        chk("step1_ret", bif.retired, 32'd7);
        bif.step_req = 1'b1;
        @(negedge clk);
        bif.step_req = 1'b0;
        @(negedge clk);
        bif.step_req = 1'b1;
        @(negedge clk);
        bif.step_req = 1'b0;
        repeat (7) @(negedge clk);
        chk("step2_idle", {28'd0, strb()}, 32'h0);
        chk("step2_ret", bif.retired, 32'd8);
        chk("step2_pc", bif.pc, 32'h8000_0020);

        // halt_req in EXEC lets the instruction retire first
        bif.step_req = 1'b1;
        @(negedge clk);
        bif.step_req = 1'b0;
        @(negedge clk);
        bif.halt_req = 1'b1;
        chk("hx_exec", {28'd0, strb()}, 32'h2);
        @(negedge clk);
        bif.halt_req = 1'b0;
        chk("hx_wb", {28'd0, strb()}, 32'h1);
        chk("hx_not_yet", {31'd0, bif.halted}, 32'h0);
        @(negedge clk);
        chk("hx_flags", {28'd0, flags()}, 32'h8);
        chk("hx_ret", bif.retired, 32'd9);
        chk("hx_pc", bif.pc, 32'h8000_0024);
        repeat (3) @(negedge clk);
        chk("hx_absorb", {28'd0, strb()}, 32'h0);

        // jump to PASS_ADDR
        rst_n           = 1'b0;
        bif.take_target = 1'b1;
        bif.target_addr = 32'h8000_0100;
        bif.step_mode   = 1'b0;
        @(negedge clk);
        chk("rst2_flags", {28'd0, flags()}, 32'h0);
        chk("rst2_ret", bif.retired, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("pass_flags", {28'd0, flags()}, 32'hC);
        chk("pass_pc", bif.pc, 32'h8000_0100);
        chk("pass_ret", bif.retired, 32'd1);
        repeat (3) @(negedge clk);
        chk("pass_quiet", {28'd0, strb()}, 32'h0);

        // jump to FAIL_ADDR
        rst_n           = 1'b0;
        bif.target_addr = 32'h8000_0104;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("fail_flags", {28'd0, flags()}, 32'hA);
        chk("fail_pc", bif.pc, 32'h8000_0104);

        // stall timeout with 4-bit counter: 15 stalled FETCH cycles
        rst_n           = 1'b0;
        bif.take_target = 1'b0;
        bif.im_ready    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("tmo_still_fetch", {28'd0, strb()}, 32'h8);
        chk("tmo_not_yet", {28'd0, flags()}, 32'h0);
        @(negedge clk);
        chk("tmo_flags", {28'd0, flags()}, 32'h9);
        chk("tmo_pc", bif.pc, 32'h8000_0000);
        chk("tmo_ret", bif.retired, 32'd0);
        chk("tmo_strb", {28'd0, strb()}, 32'h0);

        // halt_req during FETCH aborts without retiring
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst3_flags", {28'd0, flags()}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        bif.halt_req = 1'b1;
        @(negedge clk);
        bif.halt_req = 1'b0;
        chk("hf_flags", {28'd0, flags()}, 32'h8);
        chk("hf_pc", bif.pc, 32'h8000_0000);
        chk("hf_ret", bif.retired, 32'd0);

        // asynchronous reset during MEMRD
        rst_n         = 1'b0;
        bif.im_ready  = 1'b1;
        bif.is_mem_op = 1'b1;
        bif.dm_ready  = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        bif.dm_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("ar_memrd", {28'd0, strb()}, 32'h4);
        chk("ar_pre_ret", bif.retired, 32'd1);
        chk("ar_pre_pc", bif.pc, 32'h8000_0004);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_strb", {28'd0, strb()}, 32'h0);
        chk("ar_pc", bif.pc, 32'h8000_0000);
        chk("ar_ret", bif.retired, 32'd0);
        chk("ar_flags", {28'd0, flags()}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameter XLEN, 32, datapath and PC width.
REQ-002 Parameter RESET_VECTOR, 32'h8000_0000, PC value after reset.
REQ-003 Parameter PASS_ADDR, 32'h8000_0100, PC value that halts with pass.
REQ-004 Parameter FAIL_ADDR, 32'h8000_0104, PC value that halts with fail.
REQ-005 Parameter TIMEOUT_W, 8, stall-timeout counter width; all-ones limit.
REQ-006 Parameter RETIRE_W, 32, retired-instruction counter width.
REQ-007 clk  input  1  single clock; all state on posedge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 im_ready  input  1  instruction memory has valid data this cycle.
REQ-010 dm_ready  input  1  data memory read/write complete this cycle.
REQ-011 is_mem_op  input  1  decoded instruction is a load or store.
REQ-012 take_target  input  1  branch taken or jump; use target_addr.
REQ-013 target_addr  input  XLEN  next PC when take_target is high.
REQ-014 step_mode  input  1  1 = single-step, 0 = free run.
REQ-015 step_req  input  1  one-cycle pulse permitting one instruction in step mode.
REQ-016 halt_req  input  1  external halt request.
REQ-017 fetch_en, memrd_en, exec_en, wb_en  output  1 each  one-hot phase strobes.
REQ-018 pc  output  XLEN  current program counter.
REQ-019 halted, pass, fail, timeout  output  1 each  sticky status flags.
REQ-020 retired  output  RETIRE_W  count of completed write-back phases.

Function
REQ-021 FSM states IDLE, FETCH, MEMRD, EXEC, WB, HALT; exactly one phase strobe high in FETCH/MEMRD/EXEC/WB, none in IDLE/HALT.
REQ-022 IDLE -> FETCH when step_mode=0, or step_mode=1 and step_req=1; otherwise stay.
REQ-023 FETCH holds until im_ready=1, then -> MEMRD if is_mem_op=1, else -> EXEC.
REQ-024 MEMRD holds until dm_ready=1, then -> EXEC.
REQ-025 EXEC -> WB unconditionally after one cycle.
REQ-026 WB lasts one cycle: pc <= take_target ? target_addr : pc+4 (mod 2^XLEN); retired increments, wrapping at all-ones.
REQ-027 After WB: -> HALT if next pc equals PASS_ADDR or FAIL_ADDR, or halt_req=1; else -> IDLE in step mode, FETCH in free run.
REQ-028 Entering HALT via PASS_ADDR sets pass, via FAIL_ADDR sets fail; halted set on any HALT entry; pass has priority if PASS_ADDR=FAIL_ADDR.
REQ-029 halt_req sampled in FETCH, MEMRD or IDLE aborts to HALT without updating pc or retired; in EXEC it takes effect after WB.
REQ-030 Stall counter counts cycles spent waiting in FETCH or MEMRD, clears on phase exit; reaching all-ones sets timeout and -> HALT.
REQ-031 HALT is absorbing; only rst_n leaves it.
REQ-032 step_req outside IDLE is ignored; step_mode change takes effect at next IDLE/WB decision.
REQ-033 Free-run zero-wait non-memory instruction completes in 3 cycles (FETCH, EXEC, WB); memory instruction in 4.

Reset
REQ-034 rst_n low asynchronously forces state IDLE, pc=RESET_VECTOR, retired=0, stall counter=0, all strobes and flags 0.
REQ-035 Reset asserted mid-instruction discards the instruction; no pc or retired update occurs.

Structure
REQ-036 Shared package holds the state enum and the default RESET_VECTOR/PASS_ADDR/FAIL_ADDR constants.
REQ-037 One sub-module, stall_timer, implements the saturating stall counter and timeout compare.

Verification
REQ-038 Free run, im_ready=1, is_mem_op=0, take_target=0 for 4 instructions -> pc=8000_0010, retired=4 after 12 cycles.
REQ-039 is_mem_op=1, dm_ready low 3 cycles -> MEMRD held 4 cycles, memrd_en high throughout, then EXEC, WB.
REQ-040 take_target=1, target_addr=8000_0100 -> halted=1, pass=1, fail=0, pc=8000_0100, no further strobes.
REQ-041 step_mode=1, two step_req pulses 10 cycles apart -> exactly 2 instructions retired, IDLE between.
REQ-042 im_ready held 0, TIMEOUT_W=4 -> timeout=1, halted=1 after 15 stall cycles; pc unchanged.
REQ-043 rst_n low during MEMRD -> immediate IDLE, pc=8000_0000, retired=0, flags cleared.
